// File: rtl/video_scanlines_if.sv
// Video pixel bus shared by the scanline stage input and output.
// Carries blanking, both syncs and the three colour channels of one pixel.
// The producer side uses the master modport and the consumer side uses the slave modport.
interface video_scanlines_if #(
    parameter int VIDEO_DEPTH = 8
);
    logic                   hblank;
    logic                   vblank;
    logic                   hs;
    logic                   vs;
    logic [VIDEO_DEPTH-1:0] red;
    logic [VIDEO_DEPTH-1:0] green;
    logic [VIDEO_DEPTH-1:0] blue;

    modport master (
        output hblank, vblank, hs, vs, red, green, blue
    );

    modport slave (
        input  hblank, vblank, hs, vs, red, green, blue
    );
endinterface

// File: rtl/video_scanlines.sv
// video_scanlines: post-blend scanline darkening stage.
// The stage works out the hs and vs polarity by itself. It does this by comparing how long
// each sync level lasts: the shorter level is taken as the active pulse. Lines are counted
// from the normalised syncs, and every other line is darkened by a level that is latched
// at the start of each frame. All state advances only on pix_ce. Every output lags its
// input by exactly one pix_ce cycle.
// Optional macro SCANLINES_FRAME_ALT_EN: a frame bit swaps the dark lines on every frame.
module video_scanlines #(
    parameter int VIDEO_DEPTH = 8,
    parameter int HCNT_W      = 12,
    parameter int VCNT_W      = 11
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 pix_ce,
    input  logic [1:0]           scanlines,
    video_scanlines_if.slave     vid_in,
    video_scanlines_if.master    vid_out
);

    logic              hs_act_high;
    logic              vs_act_high;
    logic              hs_d;
    logic              vs_d;
    logic              hs_n_d;
    logic              vs_n_d;
    logic              parity;
    logic [1:0]        scan_lvl;
    logic [HCNT_W-1:0] hs_hi_cnt;
    logic [HCNT_W-1:0] hs_lo_cnt;
    logic [HCNT_W-1:0] hs_lo_len;
    logic [VCNT_W-1:0] vs_hi_cnt;
    logic [VCNT_W-1:0] vs_lo_cnt;
    logic [VCNT_W-1:0] vs_lo_len;
`ifdef SCANLINES_FRAME_ALT_EN
    logic              frame_bit;
`endif

    logic hs_n;
    logic vs_n;
    logic hs_rise;
    logic hs_fall;
    logic vs_rise;
    logic vs_fall;
    logic hs_lead;
    logic frame_start;
    logic dark;

    // Darkened value of one colour channel for the given level; level 0 leaves the value unchanged
    function automatic logic [VIDEO_DEPTH-1:0] shade(input logic [VIDEO_DEPTH-1:0] c,
                                                      input logic [1:0] lvl);
        logic [VIDEO_DEPTH-1:0] r;
        case (lvl)
            2'd1:    r = c - (c >> 2);
            2'd2:    r = c >> 1;
            2'd3:    r = c >> 2;
            default: r = c;
        endcase
        return r;
    endfunction

    // Raw edges, normalised syncs and the per-pixel darkening decision
    always_comb begin
        hs_n        = hs_act_high ? vid_in.hs : ~vid_in.hs;
        vs_n        = vs_act_high ? vid_in.vs : ~vid_in.vs;
        hs_rise     = vid_in.hs & ~hs_d;
        hs_fall     = ~vid_in.hs & hs_d;
        vs_rise     = vid_in.vs & ~vs_d;
        vs_fall     = ~vid_in.vs & vs_d;
        hs_lead     = hs_n & ~hs_n_d;
        frame_start = vs_n & ~vs_n_d;
        dark        = parity & ~vid_in.hblank & ~vid_in.vblank & (scan_lvl != 2'd0);
    end

    // hs polarity: the high time is compared against the previous low time, and a short high means active-high
    always_ff @(posedge clk) begin
        if (reset) begin
            hs_d        <= 1'b0;
            hs_n_d      <= 1'b0;
            hs_act_high <= 1'b1;
            hs_hi_cnt   <= '0;
            hs_lo_cnt   <= '0;
            hs_lo_len   <= '0;
        end else if (pix_ce) begin
            hs_d   <= vid_in.hs;
            hs_n_d <= hs_n;
            if (hs_rise) begin
                hs_lo_len <= hs_lo_cnt;
                hs_lo_cnt <= '0;
            end else if (!vid_in.hs && hs_lo_cnt != '1) begin
                hs_lo_cnt <= hs_lo_cnt + 1'b1;
            end
            if (hs_fall) begin
                hs_act_high <= (hs_hi_cnt < hs_lo_len);
                hs_hi_cnt   <= '0;
            end else if (vid_in.hs && hs_hi_cnt != '1) begin
                hs_hi_cnt <= hs_hi_cnt + 1'b1;
            end
        end
    end

    // vs polarity: same scheme as hs, but the durations are measured in lines (hs_n leading edges)
    always_ff @(posedge clk) begin
        if (reset) begin
            vs_d        <= 1'b0;
            vs_n_d      <= 1'b0;
            vs_act_high <= 1'b1;
            vs_hi_cnt   <= '0;
            vs_lo_cnt   <= '0;
            vs_lo_len   <= '0;
        end else if (pix_ce) begin
            vs_d   <= vid_in.vs;
            vs_n_d <= vs_n;
            if (vs_rise) begin
                vs_lo_len <= vs_lo_cnt;
                vs_lo_cnt <= '0;
            end else if (!vid_in.vs && hs_lead && vs_lo_cnt != '1) begin
                vs_lo_cnt <= vs_lo_cnt + 1'b1;
            end
            if (vs_fall) begin
                vs_act_high <= (vs_hi_cnt < vs_lo_len);
                vs_hi_cnt   <= '0;
            end else if (vid_in.vs && hs_lead && vs_hi_cnt != '1) begin
                vs_hi_cnt <= vs_hi_cnt + 1'b1;
            end
        end
    end

    // Line parity and frame-latched darkening level; a frame start takes priority over a line start
    always_ff @(posedge clk) begin
        if (reset) begin
            parity    <= 1'b0;
            scan_lvl  <= 2'd0;
`ifdef SCANLINES_FRAME_ALT_EN
            frame_bit <= 1'b0;
`endif
        end else if (pix_ce) begin
            if (frame_start) begin
                scan_lvl  <= scanlines;
`ifdef SCANLINES_FRAME_ALT_EN
                frame_bit <= ~frame_bit;
                parity    <= ~frame_bit;
`else
                parity    <= 1'b0;
`endif
            end else if (hs_lead) begin
                parity <= ~parity;
            end
        end
    end

    // Registered outputs: syncs and blanks pass through with their original polarity, colour is shaded on dark lines
    always_ff @(posedge clk) begin
        if (reset) begin
            vid_out.hblank <= 1'b0;
            vid_out.vblank <= 1'b0;
            vid_out.hs     <= 1'b0;
            vid_out.vs     <= 1'b0;
            vid_out.red    <= '0;
            vid_out.green  <= '0;
            vid_out.blue   <= '0;
        end else if (pix_ce) begin
            vid_out.hblank <= vid_in.hblank;
            vid_out.vblank <= vid_in.vblank;
            vid_out.hs     <= vid_in.hs;
            vid_out.vs     <= vid_in.vs;
            vid_out.red    <= dark ? shade(vid_in.red,   scan_lvl) : vid_in.red;
            vid_out.green  <= dark ? shade(vid_in.green, scan_lvl) : vid_in.green;
            vid_out.blue   <= dark ? shade(vid_in.blue,  scan_lvl) : vid_in.blue;
        end
    end

endmodule

// File: tb/tb_video_scanlines.sv
// Testbench for video_scanlines.
// The stimulus process drives randomised video frames. The frames use both sync
// polarities, random pix_ce gaps, mid-frame scanline changes and a long idle stretch.
// For every pix_ce cycle, a pixel-level reference model pushes the expected output
// word into a queue. A separate monitor checks the output word after every clock:
// - reset cycles must show all zeros,
// - pix_ce cycles pop the next expected word and compare it,
// - idle cycles must hold the last value.
module tb_video_scanlines;

    localparam int VD   = 8;
    localparam int HMAX = 4095;
    localparam int VMAX = 2047;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       pix_ce = 1'b0;
    logic [1:0] scanlines = 2'd0;

    video_scanlines_if #(.VIDEO_DEPTH(VD)) vin ();
    video_scanlines_if #(.VIDEO_DEPTH(VD)) vout ();

    video_scanlines #(.VIDEO_DEPTH(VD), .HCNT_W(12), .VCNT_W(11)) dut (
        .clk       (clk),
        .reset     (reset),
        .pix_ce    (pix_ce),
        .scanlines (scanlines),
        .vid_in    (vin),
        .vid_out   (vout)
    );

    always #5 clk = ~clk;

    logic [27:0] expQ[$];
    int          nCompared = 0;
    int          nMismatch = 0;

    // Reference model state, expressed as pulse widths and line/frame bookkeeping
    bit m_hsPol, m_vsPol, m_hsPrev, m_vsPrev, m_hsnPrev, m_vsnPrev, m_odd, m_frame;
    int m_hsHiRun, m_hsLoRun, m_hsLastLo, m_vsHiLines, m_vsLoLines, m_vsLastLo, m_lvl;

    function automatic int shadeRef(int c, int lvl);
        case (lvl)
            1:       return c - c / 4;
            2:       return c / 2;
            3:       return c / 4;
            default: return c;
        endcase
    endfunction

    function automatic int satInc(int v, int maxv);
        return (v < maxv) ? v + 1 : maxv;
    endfunction

    task automatic modelReset();
        m_hsPol = 1; m_vsPol = 1;
        m_hsPrev = 0; m_vsPrev = 0; m_hsnPrev = 0; m_vsnPrev = 0;
        m_odd = 0; m_frame = 0; m_lvl = 0;
        m_hsHiRun = 0; m_hsLoRun = 0; m_hsLastLo = 0;
        m_vsHiLines = 0; m_vsLoLines = 0; m_vsLastLo = 0;
    endtask

    // One pix_ce step: predict this pixel's output, then advance sync and line bookkeeping
    task automatic modelStep(bit hs, bit vs, bit hb, bit vb, int r, int g, int b, int sl);
        bit hsn, vsn, lineStart, frameStart, darken;
        logic [27:0] e;
        hsn        = m_hsPol ? hs : !hs;
        vsn        = m_vsPol ? vs : !vs;
        lineStart  = hsn && !m_hsnPrev;
        frameStart = vsn && !m_vsnPrev;
        darken     = m_odd && !hb && !vb && (m_lvl != 0);
        e = {hb, vb, hs, vs,
             8'(darken ? shadeRef(r, m_lvl) : r),
             8'(darken ? shadeRef(g, m_lvl) : g),
             8'(darken ? shadeRef(b, m_lvl) : b)};
        expQ.push_back(e);

        if (hs && !m_hsPrev) begin
            m_hsLastLo = m_hsLoRun;
            m_hsLoRun  = 0;
        end else if (!hs) m_hsLoRun = satInc(m_hsLoRun, HMAX);
        if (!hs && m_hsPrev) begin
            m_hsPol   = (m_hsHiRun < m_hsLastLo);
            m_hsHiRun = 0;
        end else if (hs) m_hsHiRun = satInc(m_hsHiRun, HMAX);

        if (vs && !m_vsPrev) begin
            m_vsLastLo  = m_vsLoLines;
            m_vsLoLines = 0;
        end else if (!vs && lineStart) m_vsLoLines = satInc(m_vsLoLines, VMAX);
        if (!vs && m_vsPrev) begin
            m_vsPol     = (m_vsHiLines < m_vsLastLo);
            m_vsHiLines = 0;
        end else if (vs && lineStart) m_vsHiLines = satInc(m_vsHiLines, VMAX);

        if (frameStart) begin
            m_lvl   = sl;
            m_frame = !m_frame;
`ifdef SCANLINES_FRAME_ALT_EN
            m_odd   = m_frame;
`else
            m_odd   = 0;
`endif
        end else if (lineStart) m_odd = !m_odd;

        m_hsPrev  = hs;
        m_vsPrev  = vs;
        m_hsnPrev = hsn;
        m_vsnPrev = vsn;
    endtask

    task automatic checkOutput(input logic [27:0] expWord, input string what);
        logic [27:0] got;
        got = {vout.hblank, vout.vblank, vout.hs, vout.vs, vout.red, vout.green, vout.blue};
        nCompared++;
        if (got !== expWord) begin
            nMismatch++;
            $display("[TB] FAIL %s at %0t: got %h required %h", what, $time, got, expWord);
        end
    endtask

    // Drive `gap` idle cycles of junk, then one pix_ce pixel with the given inputs
    task automatic applyStimulus(bit hs, bit vs, bit hb, bit vb, int r, int g, int b, int sl, int gap);
        for (int i = 0; i < gap; i++) begin
            @(negedge clk);
            pix_ce     = 1'b0;
            vin.hs     = 1'($urandom);
            vin.vs     = 1'($urandom);
            vin.hblank = 1'($urandom);
            vin.vblank = 1'($urandom);
            vin.red    = 8'($urandom);
            vin.green  = 8'($urandom);
            vin.blue   = 8'($urandom);
            scanlines  = 2'($urandom);
        end
        @(negedge clk);
        pix_ce     = 1'b1;
        vin.hs     = hs;
        vin.vs     = vs;
        vin.hblank = hb;
        vin.vblank = vb;
        vin.red    = 8'(r);
        vin.green  = 8'(g);
        vin.blue   = 8'(b);
        scanlines  = 2'(sl);
        modelStep(hs, vs, hb, vb, r, g, b, sl);
    endtask

    task automatic doReset();
        @(negedge clk);
        reset = 1'b1; pix_ce = 1'b1;
        vin.hs = 1; vin.vs = 1; vin.hblank = 1; vin.vblank = 1;
        vin.red = 8'hA5; vin.green = 8'h5A; vin.blue = 8'hFF; scanlines = 2'd3;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0; pix_ce = 1'b0;
        modelReset();
    endtask

    int curSl = 2;

    function automatic int randGap();
        int k;
        k = $urandom_range(0, 99);
        if (k < 65) return 0;
        if (k < 97) return $urandom_range(1, 2);
        return 10;
    endfunction

    task automatic runLine(int ln, bit invH, bit invV);
        int c, r, g, b;
        for (int p = 0; p < 64; p++) begin
            c = $urandom_range(0, 7);
            if (c == 0) begin r = 255; g = 255; b = 255; end
            else if (c == 1) begin r = 0; g = 0; b = 0; end
            else begin r = $urandom_range(0, 255); g = $urandom_range(0, 255); b = $urandom_range(0, 255); end
            if (p == 30 && $urandom_range(0, 2) == 0) curSl = $urandom_range(0, 3);
            applyStimulus((p < 4) ^ invH, (ln < 2) ^ invV, p < 12, ln < 3, r, g, b, curSl, randGap());
        end
    endtask

    task automatic runFrames(int n, bit invH, bit invV);
        for (int f = 0; f < n; f++)
            for (int ln = 0; ln < 12; ln++) runLine(ln, invH, invV);
    endtask

    // Monitor: classify each clock by what the DUT saw at the edge, then check outputs on the falling edge
    initial begin
        logic [27:0] held;
        bit ceQ, rstQ;
        held = '0;
        forever begin
            @(posedge clk);
            ceQ  = pix_ce;
            rstQ = reset;
            @(negedge clk);
            if (rstQ) begin
                held = '0;
                checkOutput(28'd0, "reset_zero");
            end else if (ceQ) begin
                if (expQ.size() == 0) begin
                    nCompared++;
                    nMismatch++;
                    $display("[TB] FAIL scoreboard_underflow at %0t: got output, required none pending", $time);
                end else begin
                    held = expQ.pop_front();
                    checkOutput(held, "pixel");
                end
            end else begin
                checkOutput(held, "hold");
            end
        end
    end

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vin.hs = 0; vin.vs = 0; vin.hblank = 0; vin.vblank = 0;
        vin.red = 0; vin.green = 0; vin.blue = 0;
        modelReset();
        $display("[TB] start");
        doReset();
        runFrames(5, 1'b0, 1'b0);
        doReset();
        runFrames(5, 1'b1, 1'b1);
        runFrames(2, 1'b1, 1'b0);
        runFrames(2, 1'b0, 1'b0);
        for (int i = 0; i < 4100; i++)
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, $urandom_range(0, 255),
                          $urandom_range(0, 255), $urandom_range(0, 255), curSl, 0);
        runFrames(3, 1'b0, 1'b0);
        @(negedge clk);
        pix_ce = 1'b0;
        repeat (5) @(negedge clk);
        nCompared++;
        if (expQ.size() != 0) begin
            nMismatch++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending, required 0", expQ.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule
